im_fetch_wide: RTL and testbench

- Parametrised instruction memory for the fetch stage, successor to the single-issue instruction memory.
- Returns FETCH_W consecutive instructions per cycle with per-slot valid and PC.
- Has a clocked byte-enabled load port for the test driver.
- Stall holds the fetch register instead of bubbling it. Mispredict flushes it.
- After reset, a hardware sweep clears the memory, so no bulk combinational clear is needed.

---
 rtl/im_fetch_wide.sv | 161 ++++++++++++++++
 tb/tb_im_fetch_wide.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/im_fetch_wide.sv
// Wide fetch-stage instruction memory: FETCH_W instructions per cycle,
// byte-enabled load port, and a post-reset clearing sweep.
module im_fetch_wide #(
    parameter int DEPTH   = 128,
    parameter int FETCH_W = 2,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic [31:0]           fetch_addr,
    input  logic                  stall,
    input  logic                  mispredict,
    input  logic                  wr_en,
    input  logic [31:0]           wr_addr,
    input  logic [31:0]           wr_data,
    input  logic [3:0]            wr_be,
    output logic                  init_done,
    output logic [32*FETCH_W-1:0] inst,
    output logic [32*FETCH_W-1:0] inst_pc,
    output logic [FETCH_W-1:0]    inst_valid,
    output logic                  addr_err
);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] clear_ptr_q;
    logic [AW-1:0] clear_ptr_d;
    logic          clear_we;

    logic [31:0] mem [DEPTH];

    logic [AW-1:0] fetch_w;
    logic          fetch_bad;
    logic [AW-1:0] wr_w;
    logic          wr_ok;
    logic          unused_wr_lsb;

    logic [32*FETCH_W-1:0] grp_inst;
    logic [32*FETCH_W-1:0] grp_pc;
    logic [FETCH_W-1:0]    grp_valid;
    logic [AW:0]           idx;

    assign fetch_w   = fetch_addr[AW+1:2];
    assign fetch_bad = (fetch_addr[1:0] != 2'b00)
                     | (fetch_addr[31:AW+2] != '0);
    assign wr_w      = wr_addr[AW+1:2];
    assign wr_ok     = (wr_addr[31:AW+2] == '0);
    assign unused_wr_lsb = ^wr_addr[1:0];

    // Clearing sweep: one word per cycle, then RUN until the next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clear_ptr_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        clear_we    = 1'b0;
        case (state_q)
            CLEAR: begin
                clear_we    = 1'b1;
                clear_ptr_d = clear_ptr_q + 1'b1;
                if (clear_ptr_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Storage has no reset; the sweep owns it until RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clear_we) begin
                mem[clear_ptr_q] <= '0;
            end else if (state_q == RUN && wr_en && wr_ok) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_be[b]) begin
                        mem[wr_w][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Group lookup; slots past the last word truncate instead of wrapping.
    always_comb begin
        grp_inst  = '0;
        grp_pc    = '0;
        grp_valid = '0;
        idx       = '0;
        for (int k = 0; k < FETCH_W; k++) begin
            idx = {1'b0, fetch_w} + (AW+1)'(k);
            grp_pc[32*k +: 32] = fetch_addr + 32'(4 * k);
            if (!idx[AW]) begin
                grp_inst[32*k +: 32] = mem[idx[AW-1:0]];
                grp_valid[k]         = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_done  <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= '0;
            addr_err   <= 1'b0;
        end else begin
            init_done <= (state_d == RUN);
            if (state_q == RUN) begin
                priority case (1'b1)
                    mispredict: begin
                        inst       <= '0;
                        inst_pc    <= '0;
                        inst_valid <= '0;
                        addr_err   <= 1'b0;
                    end
                    stall: begin
                        inst       <= inst;
                        inst_pc    <= inst_pc;
                        inst_valid <= inst_valid;
                        addr_err   <= addr_err;
                    end
                    !fetch_en: begin
                        inst_valid <= '0;
                        addr_err   <= 1'b0;
                    end
                    fetch_bad: begin
                        inst_valid <= '0;
                        addr_err   <= 1'b1;
                    end
                    default: begin
                        inst       <= grp_inst;
                        inst_pc    <= grp_pc;
                        inst_valid <= grp_valid;
                        addr_err   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_im_fetch_wide.sv
// Directed bench for im_fetch_wide (DEPTH=128, FETCH_W=2).
module tb_im_fetch_wide;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        stall = 1'b0;
    logic        mispredict = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        init_done;
    logic [63:0] inst;
    logic [63:0] inst_pc;
    logic [1:0]  inst_valid;
    logic        addr_err;

    int vectors = 0;
    int miscompares = 0;

    im_fetch_wide #(.DEPTH(128), .FETCH_W(2)) dut (
        .clk(clk), .rst(rst),
        .fetch_en(fetch_en), .fetch_addr(fetch_addr),
        .stall(stall), .mispredict(mispredict),
        .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be),
        .init_done(init_done), .inst(inst),
        .inst_pc(inst_pc), .inst_valid(inst_valid),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        fetch_en = 1'b1; fetch_addr = a;
        tick();
        fetch_en = 1'b0;
    endtask

    // Counts edges until init_done, noting any valid output meanwhile.
    task automatic wait_init(output int n, output logic saw_valid);
        n = 0;
        saw_valid = 1'b0;
        while (n < 200) begin
            tick();
            n++;
            if (inst_valid != 2'b00) saw_valid = 1'b1;
            if (init_done) break;
        end
    endtask

    int   n;
    logic sv;

    initial begin
        tick();
        tick();
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst", inst, 64'd0);
        chk("rst_pc", inst_pc, 64'd0);
        chk("rst_err", 64'(addr_err), 64'd0);

        rst = 1'b0;
        fetch_en = 1'b1; fetch_addr = 32'h0;
        wr_en = 1'b1; wr_addr = 32'h28;
        wr_data = 32'hDEADBEEF; wr_be = 4'hF;
        wait_init(n, sv);
        fetch_en = 1'b0; wr_en = 1'b0;
        chk("clear_cycles", 64'(n), 64'd128);
        chk("clear_no_valid", 64'(sv), 64'd0);

        wr(32'h0, 32'h11111111, 4'hF);
        wr(32'h4, 32'h22222222, 4'hF);
        wr(32'h8, 32'h33333333, 4'hF);
        wr(32'hC, 32'h44444444, 4'hF);
        fetch(32'h4);
        chk("f4_inst", inst, 64'h33333333_22222222);
        chk("f4_pc", inst_pc, 64'h00000008_00000004);
        chk("f4_valid", 64'(inst_valid), 64'd3);
        chk("f4_err", 64'(addr_err), 64'd0);

        tick();
        chk("idle_valid", 64'(inst_valid), 64'd0);
        chk("idle_inst_hold", inst, 64'h33333333_22222222);

        fetch(32'h28);
        chk("clear_wr_dropped", inst, 64'd0);
        chk("f28_valid", 64'(inst_valid), 64'd3);

        wr(32'h1FC, 32'h7F7F7F7F, 4'hF);
        fetch(32'h1FC);
        chk("end_valid", 64'(inst_valid), 64'd1);
        chk("end_inst", inst, 64'h00000000_7F7F7F7F);
        chk("end_pc", inst_pc, 64'h00000200_000001FC);

        fetch(32'h200);
        chk("oor_valid", 64'(inst_valid), 64'd0);
        chk("oor_err", 64'(addr_err), 64'd1);
        fetch(32'h6);
        chk("mis_valid", 64'(inst_valid), 64'd0);
        chk("mis_err", 64'(addr_err), 64'd1);

        fetch(32'h4);
        chk("f4b_err", 64'(addr_err), 64'd0);
        stall = 1'b1; fetch_en = 1'b1; fetch_addr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_inst", inst, 64'h33333333_22222222);
            chk("stall_pc", inst_pc, 64'h00000008_00000004);
            chk("stall_valid", 64'(inst_valid), 64'd3);
        end
        mispredict = 1'b1;
        tick();
        chk("flush_valid", 64'(inst_valid), 64'd0);
        chk("flush_inst", inst, 64'd0);
        chk("flush_pc", inst_pc, 64'd0);
        stall = 1'b0; mispredict = 1'b0; fetch_en = 1'b0;

        wr(32'h14, 32'hAABBCCDD, 4'hF);
        wr_en = 1'b1; wr_addr = 32'h14;
        wr_data = 32'h11223344; wr_be = 4'b0101;
        fetch(32'h14);
        wr_en = 1'b0;
        chk("rf_old", inst, 64'h00000000_AABBCCDD);
        fetch(32'h14);
        chk("rf_new", inst, 64'h00000000_AA22CC44);

        wr(32'h8000001C, 32'h55555555, 4'hF);
        fetch(32'h1C);
        chk("wr_oor_dropped", inst, 64'h00000000_00000000);
        wr(32'h23, 32'h12345678, 4'hF);
        fetch(32'h20);
        chk("wr_lsb_ignored", inst, 64'h00000000_12345678);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rrun_valid", 64'(inst_valid), 64'd0);
        chk("rrun_inst", inst, 64'd0);
        chk("rrun_init", 64'(init_done), 64'd0);
        repeat (64) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmid_init", 64'(init_done), 64'd0);
        wait_init(n, sv);
        chk("reclear_cycles", 64'(n), 64'd128);
        fetch(32'h0);
        chk("reclear_word0", inst, 64'd0);
        chk("reclear_valid", 64'(inst_valid), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
